// File: rtl/led_ctrl.sv
// rtl/led_ctrl.sv - multi-channel LED driver (OFF/ON/BLINK/PWM) with register write/readback port
// Optional feature macro: LED_BREATHE_EN turns mode 11 into a breathing duty ramp.
module led_ctrl #(
    parameter int CLK_FREQ   = 80000000,
    parameter int TICK_HZ    = 1000,
    parameter int NUM_LEDS   = 8,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [3:0]          addr,
    input  logic [15:0]         wr_data,
    input  logic                rd_en,
    output logic [15:0]         rd_data,
    output logic                rd_valid,
    output logic                tick,
    output logic [NUM_LEDS-1:0] led
);
    localparam int TICK_DIV = CLK_FREQ / TICK_HZ;
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PCNT_MAX = PW'(TICK_DIV - 1);
    localparam logic [NUM_LEDS-1:0] LED_INV = (ACTIVE_LOW != 0) ? '1 : '0;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_PWM   = 2'b11
    } mode_t;

    logic [PW-1:0]       pcnt;
    logic [7:0]          pwm_cnt;
    mode_t               mode  [NUM_LEDS];
    logic [7:0]          param [NUM_LEDS];
    logic [7:0]          bcnt  [NUM_LEDS];
    logic [7:0]          level [NUM_LEDS];
    logic [NUM_LEDS-1:0] phase;
    logic [NUM_LEDS-1:0] lit;
    logic [15:0]         rd_val;
    logic                unused_reserved;
`ifdef LED_BREATHE_EN
    logic [7:0]          duty  [NUM_LEDS];
    logic [NUM_LEDS-1:0] dir_up;
`endif

    assign unused_reserved = ^wr_data[13:8];
    assign tick = (pcnt == PCNT_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt    <= '0;
            pwm_cnt <= '0;
        end else begin
            pcnt    <= tick ? '0 : pcnt + 1'b1;
            pwm_cnt <= pwm_cnt + 8'd1;
        end
    end

    // A write to a channel takes priority over a tick landing in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                mode[i]  <= MODE_OFF;
                param[i] <= '0;
                bcnt[i]  <= '0;
`ifdef LED_BREATHE_EN
                duty[i]  <= '0;
`endif
            end
            phase <= '0;
`ifdef LED_BREATHE_EN
            dir_up <= '0;
`endif
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (wr_en && addr == 4'(i)) begin
                    mode[i]  <= mode_t'(wr_data[15:14]);
                    param[i] <= wr_data[7:0];
                    bcnt[i]  <= '0;
                    phase[i] <= 1'b1;
`ifdef LED_BREATHE_EN
                    duty[i]   <= wr_data[7:0];
                    dir_up[i] <= 1'b1;
`endif
                end else if (tick) begin
                    if (mode[i] == MODE_BLINK) begin
                        if (bcnt[i] == param[i]) begin
                            bcnt[i]  <= '0;
                            phase[i] <= ~phase[i];
                        end else begin
                            bcnt[i] <= bcnt[i] + 8'd1;
                        end
                    end
`ifdef LED_BREATHE_EN
                    // Reflect at the rails so the ramp reads 254,255,254 and 1,0,1.
                    if (mode[i] == MODE_PWM) begin
                        if (dir_up[i]) begin
                            if (duty[i] == 8'hFF) begin
                                duty[i]   <= 8'hFE;
                                dir_up[i] <= 1'b0;
                            end else begin
                                duty[i] <= duty[i] + 8'd1;
                            end
                        end else begin
                            if (duty[i] == 8'h00) begin
                                duty[i]   <= 8'h01;
                                dir_up[i] <= 1'b1;
                            end else begin
                                duty[i] <= duty[i] - 8'd1;
                            end
                        end
                    end
`endif
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_LEDS; i++) begin
            level[i] = param[i];
`ifdef LED_BREATHE_EN
            if (mode[i] == MODE_PWM) level[i] = duty[i];
`endif
        end
    end

    always_comb begin
        lit = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            case (mode[i])
                MODE_OFF:   lit[i] = 1'b0;
                MODE_ON:    lit[i] = 1'b1;
                MODE_BLINK: lit[i] = phase[i];
                default:    lit[i] = (pwm_cnt < level[i]);
            endcase
        end
    end

    // Out-of-range addresses match no channel and therefore read back 0.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (addr == 4'(i)) rd_val = {mode[i], 6'b0, level[i]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led      <= LED_INV;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            led      <= lit ^ LED_INV;
            rd_valid <= rd_en;
            if (rd_en) rd_data <= rd_val;
        end
    end
endmodule

// File: tb/tb_led_ctrl.sv
// tb/tb_led_ctrl.sv - randomized self-checking bench for led_ctrl against a tick/time-based model
module tb_led_ctrl;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         wr_en = 1'b0;
    logic         rd_en = 1'b0;
    logic [3:0]   addr = '0;
    logic [15:0]  wr_data = '0;
    logic [15:0]  rd_data;
    logic         rd_valid;
    logic         tick;
    logic [N-1:0] led;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Model: current and previous configuration per channel, plus the edge index it took effect.
    logic [1:0] m_mode [N];
    logic [7:0] m_param [N];
    int         m_w [N];
    logic [1:0] p_mode [N];
    logic [7:0] p_param [N];
    int         p_w [N];

    led_ctrl #(
        .CLK_FREQ(100), .TICK_HZ(10), .NUM_LEDS(N), .ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .addr(addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .tick(tick), .led(led)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Lit state after j clock edges; ticks are consumed on edges that are multiples of 10.
    function automatic bit lit_of(int mode, int param, int w, int j);
        int n;
        if (mode == 1) return 1'b1;
        if (mode == 2) begin
            n = j / 10 - w / 10;
            return ((n / (param + 1)) % 2) == 0;
        end
        if (mode == 3) return (j % 256) < param;
        return 1'b0;
    endfunction

    function automatic logic [N-1:0] exp_led(int k);
        logic [N-1:0] v;
        for (int c = 0; c < N; c++) begin
            if (m_w[c] <= k - 1) v[c] = lit_of(m_mode[c], m_param[c], m_w[c], k - 1);
            else                 v[c] = lit_of(p_mode[c], p_param[c], p_w[c], k - 1);
        end
        return v;
    endfunction

    function automatic logic [15:0] exp_reg(int a);
        if (a >= N) return 16'h0000;
        return {m_mode[a], 6'b000000, m_param[a]};
    endfunction

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_mode[c] = 0; m_param[c] = 0; m_w[c] = 0;
            p_mode[c] = 0; p_param[c] = 0; p_w[c] = 0;
        end
    endtask

    task automatic drive_write(input int a, input logic [15:0] d);
        wr_en = 1'b1;
        addr = 4'(a);
        wr_data = d;
        if (a < N) begin
            p_mode[a] = m_mode[a]; p_param[a] = m_param[a]; p_w[a] = m_w[a];
            m_mode[a] = d[15:14]; m_param[a] = d[7:0]; m_w[a] = cyc + 1;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checks++; if (led !== 4'b0000) begin errors++; $display("FAIL reset_led: got %b expected 0000", led); end
        checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0000", rd_data); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
        drive_write(0, 16'h4000);
        next_cycle();
        rd_en = 1'b1; addr = 4'd0;
        next_cycle();
        checks++; if (rd_data !== 16'h4000) begin errors++; $display("FAIL pre_reset_read: got %h expected 4000", rd_data); end
        checks++; if (led[0] !== 1'b1) begin errors++; $display("FAIL pre_reset_led0: got %b expected 1", led[0]); end
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        checks++; if (led !== 4'b0000) begin errors++; $display("FAIL async_reset_led: got %b expected 0000", led); end
        checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL async_reset_rd_data: got %h expected 0000", rd_data); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL async_reset_tick: got %b expected 0", tick); end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 35; i++) begin
            next_cycle();
            checks++; if (tick !== ((cyc % 10) == 9)) begin errors++; $display("FAIL tick_period: cyc %0d got %b expected %b", cyc, tick, (cyc % 10) == 9); end
            checks++; if (led !== 4'b0000) begin errors++; $display("FAIL post_reset_led: got %b expected 0000", led); end
        end
    endtask

    task automatic test_on_off();
        drive_write(0, 16'h4000);
        next_cycle();
        checks++; if (led[0] !== 1'b0) begin errors++; $display("FAIL on_latency_early: got %b expected 0", led[0]); end
        next_cycle();
        checks++; if (led[0] !== 1'b1) begin errors++; $display("FAIL on_lit: got %b expected 1", led[0]); end
        checks++; if (led !== exp_led(cyc)) begin errors++; $display("FAIL on_model: got %b expected %b", led, exp_led(cyc)); end
        drive_write(0, 16'h0000);
        next_cycle();
        checks++; if (led[0] !== 1'b1) begin errors++; $display("FAIL off_latency_early: got %b expected 1", led[0]); end
        next_cycle();
        checks++; if (led[0] !== 1'b0) begin errors++; $display("FAIL off_dark: got %b expected 0", led[0]); end
    endtask

    task automatic test_blink();
        drive_write(1, 16'h8002);
        for (int i = 0; i < 135; i++) begin
            next_cycle();
            checks++; if (led !== exp_led(cyc)) begin errors++; $display("FAIL blink: cyc %0d got %b expected %b", cyc, led, exp_led(cyc)); end
        end
        drive_write(1, 16'h8002);
        for (int i = 0; i < 75; i++) begin
            next_cycle();
            checks++; if (led !== exp_led(cyc)) begin errors++; $display("FAIL blink_rewrite: cyc %0d got %b expected %b", cyc, led, exp_led(cyc)); end
        end
    endtask

    task automatic test_pwm();
        logic [7:0] duties [3];
        int hi;
        duties[0] = 8'h40; duties[1] = 8'h00; duties[2] = 8'hFF;
        for (int t = 0; t < 3; t++) begin
            drive_write(2, {2'b11, 6'b000000, duties[t]});
            next_cycle();
            next_cycle();
            hi = 0;
            for (int i = 0; i < 256; i++) begin
                next_cycle();
                hi += int'(led[2]);
                checks++; if (led !== exp_led(cyc)) begin errors++; $display("FAIL pwm: cyc %0d got %b expected %b", cyc, led, exp_led(cyc)); end
            end
            checks++; if (hi != int'(duties[t])) begin errors++; $display("FAIL pwm_duty_count: got %0d expected %0d", hi, duties[t]); end
        end
    endtask

    task automatic test_bounds();
        logic [15:0] e;
        drive_write(4, 16'h4000);
        next_cycle();
        next_cycle();
        checks++; if (led !== exp_led(cyc)) begin errors++; $display("FAIL oob_write: got %b expected %b", led, exp_led(cyc)); end
        rd_en = 1'b1; addr = 4'd4;
        next_cycle();
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL oob_rd_valid: got %b expected 1", rd_valid); end
        checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL oob_rd_data: got %h expected 0000", rd_data); end
        drive_write(1, 16'h8002);
        next_cycle();
        e = exp_reg(1);
        rd_en = 1'b1;
        drive_write(1, 16'h7F12);
        next_cycle();
        checks++; if (rd_data !== e) begin errors++; $display("FAIL rw_same_cycle: got %h expected %h", rd_data, e); end
        rd_en = 1'b1; addr = 4'd1;
        next_cycle();
        checks++; if (rd_data !== 16'h4012) begin errors++; $display("FAIL reserved_dropped: got %h expected 4012", rd_data); end
    endtask

    task automatic test_random();
        bit          do_rd;
        int          ra;
        int          a;
        logic [1:0]  md;
        logic [7:0]  pm;
        logic [15:0] erd;
        erd = '0;
        for (int it = 0; it < 400; it++) begin
            do_rd = ($urandom_range(0, 2) == 0);
            ra = $urandom_range(0, 5);
            if (do_rd) begin
                rd_en = 1'b1; addr = 4'(ra); erd = exp_reg(ra);
            end
            if ($urandom_range(0, 3) == 0) begin
                a = do_rd ? ra : $urandom_range(0, 5);
`ifdef LED_BREATHE_EN
                md = 2'($urandom_range(0, 2));
`else
                md = 2'($urandom_range(0, 3));
`endif
                pm = (md == 2'b10) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
                drive_write(a, {md, 6'($urandom), pm});
            end
            next_cycle();
            checks++; if (led !== exp_led(cyc)) begin errors++; $display("FAIL rand_led: cyc %0d got %b expected %b", cyc, led, exp_led(cyc)); end
            checks++; if (tick !== ((cyc % 10) == 9)) begin errors++; $display("FAIL rand_tick: cyc %0d got %b expected %b", cyc, tick, (cyc % 10) == 9); end
            checks++; if (rd_valid !== do_rd) begin errors++; $display("FAIL rand_rd_valid: got %b expected %b", rd_valid, do_rd); end
            if (do_rd) begin
                checks++; if (rd_data !== erd) begin errors++; $display("FAIL rand_rd_data: addr %0d got %h expected %h", ra, rd_data, erd); end
            end
        end
    endtask

`ifdef LED_BREATHE_EN
    task automatic wait_tick_consumed();
        int n;
        n = 0;
        while (tick !== 1'b1 && n < 20) begin next_cycle(); n++; end
        checks++; if (n >= 20) begin errors++; $display("FAIL breathe_tick_timeout: got none expected tick"); end
        next_cycle();
    endtask

    task automatic test_breathe();
        logic [7:0] d;
        bit up;
        wait_tick_consumed();
        drive_write(3, 16'hC0FE);
        next_cycle();
        d = 8'hFE; up = 1'b1;
        for (int s = 0; s < 4; s++) begin
            rd_en = 1'b1; addr = 4'd3;
            next_cycle();
            checks++; if (rd_data !== {8'hC0, d}) begin errors++; $display("FAIL breathe_duty: step %0d got %h expected %h", s, rd_data, {8'hC0, d}); end
            wait_tick_consumed();
            if (up) begin
                if (d == 8'hFF) begin d = 8'hFE; up = 1'b0; end else d = d + 8'd1;
            end else begin
                if (d == 8'h00) begin d = 8'h01; up = 1'b1; end else d = d - 8'd1;
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_on_off();
        test_blink();
`ifndef LED_BREATHE_EN
        test_pwm();
`endif
        test_bounds();
        test_random();
`ifdef LED_BREATHE_EN
        test_breathe();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
